// File: rtl/decode_issue.sv
// RV32I decode-and-issue stage: field extraction, busy-bit scoreboard and one-entry output register.
// Optional macro DECODE_WB_BYPASS_EN lets a same-cycle writeback clear the hazard check.
module decode_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [31:0]     imm,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic [31:0]     busy_map
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [6:0]      opcode_q, funct7_q;
  logic [2:0]      funct3_q;
  logic [31:0]     imm_q;
  logic            rd_we_q, illegal_q;
  logic [31:0]     busy_q, busy_d;

  logic [6:0]  dec_op;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  logic        dec_known, use_rs1, use_rs2, writes_rd, dec_rd_we;
  logic [31:0] hazard_busy;
  logic        hazard, accept;

  assign dec_op  = in_instr[6:0];
  assign dec_rs1 = in_instr[19:15];
  assign dec_rs2 = in_instr[24:20];
  assign dec_rd  = in_instr[11:7];

  always_comb begin
    dec_known = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    dec_imm   = '0;
    case (dec_op)
      OpReg: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OpImm, OpLoad, OpJalr: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OpBranch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OpJal: begin
        writes_rd = 1'b1;
        dec_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      OpLui, OpAuipc: begin
        writes_rd = 1'b1;
        dec_imm   = {in_instr[31:12], 12'b0};
      end
      // Ordering and system instructions touch no scoreboarded registers.
      OpFence, OpSystem: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      default: dec_known = 1'b0;
    endcase
  end

  assign dec_rd_we = dec_known && writes_rd && (dec_rd != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
  logic [31:0] wb_mask;
  assign wb_mask     = wb_en ? (32'd1 << wb_rd) : 32'd0;
  assign hazard_busy = busy_q & ~wb_mask;
`else
  assign hazard_busy = busy_q;
`endif

  assign hazard = dec_known && ((use_rs1 && hazard_busy[dec_rs1]) ||
                                (use_rs2 && hazard_busy[dec_rs2]) ||
                                (dec_rd_we && hazard_busy[dec_rd]));

  assign out_valid = (state_q == StFull);
  assign in_ready  = !flush && (!out_valid || out_ready) && !hazard;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (out_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (flush) state_d = StEmpty;
  end

  // Set beats clear; a flushed bundle releases its own destination.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (flush && out_valid && rd_we_q) busy_d[rd_q] = 1'b0;
    if (accept && dec_rd_we) busy_d[dec_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      pc_q      <= in_pc;
      rs1_q     <= dec_rs1;
      rs2_q     <= dec_rs2;
      rd_q      <= dec_rd;
      opcode_q  <= dec_op;
      funct3_q  <= in_instr[14:12];
      funct7_q  <= in_instr[31:25];
      imm_q     <= dec_imm;
      rd_we_q   <= dec_rd_we;
      illegal_q <= !dec_known;
    end
  end

  assign out_pc   = pc_q;
  assign rs1      = rs1_q;
  assign rs2      = rs2_q;
  assign rd       = rd_q;
  assign opcode   = opcode_q;
  assign funct3   = funct3_q;
  assign funct7   = funct7_q;
  assign imm      = imm_q;
  assign rd_we    = rd_we_q;
  assign illegal  = illegal_q;
  assign busy_map = busy_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: expected bundles queued on accept, compared on consume.
module tb_decode_issue;

  typedef struct {
    logic [31:0] pc;
    int          rs1;  // -1: not compared
    int          rs2;
    int          rd;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        rd_we, illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_map;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic got;
  int   waits;

  decode_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imm(imm), .rd_we(rd_we), .illegal(illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush), .busy_map(busy_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input int r1, input int r2, input int rdi,
                              input logic [31:0] im, input logic we, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = r1; e.rs2 = r2; e.rd = rdi;
    e.imm = im; e.rd_we = we; e.illegal = ill;
    return e;
  endfunction

  // Observe at the falling edge (inputs are stable then), return at posedge+1.
  task automatic tick(output logic acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (rst_n) begin
      if (flush && out_valid && sb.size() > 0) void'(sb.pop_front());
      else if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("unexpected_bundle", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check_eq("sb_pc", out_pc, e.pc);
          if (e.rs1 >= 0) check_eq("sb_rs1", {27'd0, rs1}, e.rs1);
          if (e.rs2 >= 0) check_eq("sb_rs2", {27'd0, rs2}, e.rs2);
          if (e.rd >= 0)  check_eq("sb_rd", {27'd0, rd}, e.rd);
          check_eq("sb_imm", imm, e.imm);
          check_eq("sb_rd_we", {31'd0, rd_we}, {31'd0, e.rd_we});
          check_eq("sb_illegal", {31'd0, illegal}, {31'd0, e.illegal});
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                       output int n);
    logic acc;
    cur_exp  = e;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) check_eq("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", busy_map, 32'd0);
    check_eq("rst_imm", imm, 32'd0);
    rst_n = 1'b1;
    tick(got);

    // addi x5,x0,7 then dependent add x6,x5,x5
    issue(32'h00700293, 32'h100, mk(32'h100, 0, -1, 5, 32'd7, 1'b1, 1'b0), waits);
    in_instr = 32'h00528333; in_pc = 32'h104; in_valid = 1'b1;
    cur_exp = mk(32'h104, 5, 5, 6, 32'd0, 1'b1, 1'b0);
    #1;
    check_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_rd", {27'd0, rd}, 32'd5);
    check_eq("addi_rs1", {27'd0, rs1}, 32'd0);
    check_eq("addi_imm", imm, 32'd7);
    check_eq("addi_rd_we", {31'd0, rd_we}, 32'd1);
    check_eq("addi_busy", busy_map, 32'h20);
    check_eq("raw_stall", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick(got);
      check_eq("raw_stall_hold", {31'd0, got}, 32'd0);
    end
    wb_en = 1'b1; wb_rd = 5'd5;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check_eq("bypass_ready", {31'd0, in_ready}, 32'd1);
    tick(got);
    check_eq("bypass_accept", {31'd0, got}, 32'd1);
    wb_en = 1'b0; in_valid = 1'b0;
`else
    check_eq("wb_cycle_ready", {31'd0, in_ready}, 32'd0);
    tick(got);
    check_eq("wb_cycle_accept", {31'd0, got}, 32'd0);
    wb_en = 1'b0;
    #1;
    check_eq("post_wb_ready", {31'd0, in_ready}, 32'd1);
    tick(got);
    check_eq("post_wb_accept", {31'd0, got}, 32'd1);
    in_valid = 1'b0;
`endif
    #1;
    check_eq("add_busy", busy_map, 32'h40);
    tick(got);
    wb_en = 1'b1; wb_rd = 5'd6;
    tick(got);
    wb_en = 1'b0;
    #1;
    check_eq("retire_x6", busy_map, 32'd0);

    // sw x5,-4(x2)
    issue(32'hFE512E23, 32'h108, mk(32'h108, 2, 5, -1, 32'hFFFFFFFC, 1'b0, 1'b0), waits);
    #1;
    check_eq("sw_busy", busy_map, 32'd0);
    check_eq("sw_rd_we", {31'd0, rd_we}, 32'd0);
    tick(got);

    // lui x1 held for three cycles
    out_ready = 1'b0;
    issue(32'h123450B7, 32'h10C, mk(32'h10C, -1, -1, 1, 32'h12345000, 1'b1, 1'b0), waits);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("lui_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("lui_hold_imm", imm, 32'h12345000);
      check_eq("lui_hold_pc", out_pc, 32'h10C);
      check_eq("lui_hold_ready", {31'd0, in_ready}, 32'd0);
      tick(got);
    end
    out_ready = 1'b1;
    tick(got);
    #1;
    check_eq("lui_drained", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_rd = 5'd1;
    tick(got);
    wb_en = 1'b0;

    // back-to-back independent issue
    issue(32'h00100393, 32'h110, mk(32'h110, 0, -1, 7, 32'd1, 1'b1, 1'b0), waits);
    check_eq("tput_first", waits, 32'd1);
    issue(32'hFFF00413, 32'h114, mk(32'h114, 0, -1, 8, 32'hFFFFFFFF, 1'b1, 1'b0), waits);
    check_eq("tput_second", waits, 32'd1);
    #1;
    check_eq("tput_busy", busy_map, 32'h180);
    tick(got);
    wb_en = 1'b1; wb_rd = 5'd7;
    tick(got);
    wb_rd = 5'd8;
    tick(got);
    wb_en = 1'b0;

    // flush a held addi x5, then add issues with no writeback
    out_ready = 1'b0;
    issue(32'h00700293, 32'h200, mk(32'h200, 0, -1, 5, 32'd7, 1'b1, 1'b0), waits);
    #1;
    check_eq("flush_pre_busy", busy_map, 32'h20);
    flush = 1'b1;
    #1;
    check_eq("flush_ready", {31'd0, in_ready}, 32'd0);
    tick(got);
    flush = 1'b0;
    #1;
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_busy", busy_map, 32'd0);
    out_ready = 1'b1;
    issue(32'h00528333, 32'h204, mk(32'h204, 5, 5, 6, 32'd0, 1'b1, 1'b0), waits);
    check_eq("add_after_flush", waits, 32'd1);
    tick(got);

    // illegal opcode, then asynchronous reset mid-stream
    out_ready = 1'b0;
    issue(32'h0000007F, 32'h300, mk(32'h300, -1, -1, -1, 32'd0, 1'b0, 1'b1), waits);
    #1;
    check_eq("ill_flag", {31'd0, illegal}, 32'd1);
    check_eq("ill_rd_we", {31'd0, rd_we}, 32'd0);
    check_eq("ill_imm", imm, 32'd0);
    check_eq("ill_busy", busy_map, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_busy", busy_map, 32'd0);
    check_eq("arst_illegal", {31'd0, illegal}, 32'd0);
    check_eq("arst_pc", out_pc, 32'd0);
    check_eq("arst_rd", {27'd0, rd}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(got);
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage sitting directly upstream of the `registers` file. It accepts fetched RV32I instructions over a valid/ready handshake and extracts the `rs1`/`rs2`/`rd` indices, immediate and control fields. A 32-entry busy scoreboard stalls read-after-write and write-after-write hazards until the writeback stage retires the producing instruction. The decoded bundle is held in a one-entry output register that feeds register-file reads and execute.

## Interface
Parameters:
- `XLEN`, 32, data/PC width.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  downstream consumes the bundle.
- `out_pc`  out  XLEN  latched PC.
- `rs1`, `rs2`, `rd`  out  5  register indices; drive the register-file ports.
- `opcode`  out  7; `funct3`  out  3; `funct7`  out  7.
- `imm`  out  32  sign-extended immediate.
- `rd_we`  out  1  instruction writes a nonzero `rd`.
- `illegal`  out  1  unknown opcode.
- `wb_en`  in  1  writeback retires a write.
- `wb_rd`  in  5  retired destination.
- `flush`  in  1  kill the held bundle.
- `busy_map`  out  32  scoreboard, for debug.

## Operation
- Output register states: EMPTY (`out_valid`=0) and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when `out_ready` is high and there is no accept.
  - FULL -> FULL on a simultaneous consume and accept.
  - Any state -> EMPTY on `flush`.
- `in_ready` = !`flush` && (!`out_valid` || `out_ready`) && !hazard. Accept = `in_valid` && `in_ready`.
- Source and destination use by opcode:
  - `rs1` is used by 0110011, 0010011, 0000011, 0100011, 1100011 and 1100111.
  - `rs2` is used by 0110011, 0100011 and 1100011.
  - `rd` is written by 0110011, 0010011, 0000011, 1101111, 1100111, 0110111 and 0010111, with `rd`!=0.
- Hazard = (rs1 used && busy[rs1]) || (rs2 used && busy[rs2]) || (rd written && busy[rd]).
- Immediate formats: I, S, B, U, J per the RV32I spec, sign-extended from bit 31.
- Unknown opcode: `illegal`=1, `rd_we`=0, `imm`=0; no hazard check, no scoreboard update.
- Scoreboard:
  - On accept with `rd_we`, set busy[rd].
  - On `wb_en` with `wb_rd`!=0, clear busy[wb_rd].
  - busy[0] is always 0.
  - If a set and a clear hit the same index in one cycle, the set wins.
- `flush` clears `out_valid` and clears busy[rd] of the held bundle if it had `rd_we`. A flush with the output register EMPTY has no effect on the scoreboard.
- Reset: `out_valid`=0, all output fields 0, `busy_map`=0.

## Timing
- Latency: accept at edge N gives a valid bundle during cycle N+1.
- Throughput: 1 instruction/cycle when there is no hazard and `out_ready` is held high.
- Outputs stay stable while `out_valid` && !`out_ready`.
- A scoreboard clear at edge N unblocks the dependent instruction at edge N+1 (without the bypass).
- Reset asserted mid-operation drops the held bundle and the scoreboard immediately, with no writeback needed.

## Configuration
- `DECODE_WB_BYPASS_EN`
  - Defined: the hazard check uses busy & ~(`wb_en` ? onehot(`wb_rd`) : 0). A dependent instruction issues in the same cycle its producer retires, giving one stall cycle less.
  - Undefined: the hazard check uses the registered busy bits only.

## Test plan
- Reset, then present `addi x5,x0,7` (0x00700293) -> next cycle: `out_valid`=1, `rd`=5, `rs1`=0, `imm`=7, `rd_we`=1, `busy_map`=0x00000020.
- `add x6,x5,x5` (0x00528333) right after that -> `in_ready`=0 until `wb_en`=1 with `wb_rd`=5.
  - Accepted one cycle after the writeback without the bypass macro.
  - Accepted in the same cycle with the macro.
- `sw x5,-4(x2)` (0xFE512E23) -> `imm`=0xFFFFFFFC, `rs1`=2, `rs2`=5, `rd_we`=0, `busy_map` unchanged.
- `lui x1,0x12345` (0x123450B7) with `out_ready`=0 for 3 cycles -> bundle held stable: `imm`=0x12345000, `in_ready`=0, then drains on `out_ready`=1.
- Issue `addi x5,x0,7`, then `flush` while the bundle is held -> `out_valid`=0, busy[5]=0; a following `add x6,x5,x5` is accepted without a writeback.
- Opcode 0x7F -> `illegal`=1, `rd_we`=0, `imm`=0, `busy_map` unchanged; then assert `rst_n`=0 mid-stream -> all outputs 0 asynchronously.
